free_list: RTL
==============

# free_list

Physical-register free list for the rename stage, sitting directly upstream of the physical register file. It hands out one free physical register per cycle to rename, drives the PRF's `alloc_inval_i`/`alloc_preg_i` for that register, and reclaims the previous mapping's register at commit. It takes per-branch checkpoints of its allocation pointer and restores them on branch recovery or full pipeline flush, in lock-step with the PRF's checkpoint/recover ports.

## Interface
Parameters:
- `N_PHYS_REGS`, 128: physical registers; power of two; also the circular-buffer depth.
- `N_ARCH_REGS`, 32: architectural registers; pregs 0..N_ARCH_REGS-1 are mapped at reset.
- `ROB_DEPTH`, 16: checkpoint slots, indexed by ROB tag.
- `PREG_W`, $clog2(N_PHYS_REGS); `ROB_W`, $clog2(ROB_DEPTH).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `alloc_req_i`  in  1  rename wants one preg this cycle
- `alloc_valid_o`  out  1  a free preg is offered this cycle
- `alloc_preg_o`  out  PREG_W  offered preg (buffer[head])
- `alloc_inval_o`  out  1  pop this cycle; drives PRF `alloc_inval_i`
- `commit_i`  in  1  an instruction retires this cycle
- `commit_rd_used_i`  in  1  retiring instruction renamed a destination
- `commit_old_preg_i`  in  PREG_W  previous mapping to free; never 0 when rd_used
- `checkpoint_take_i`  in  1  snapshot head
- `checkpoint_tag_i`  in  ROB_W  snapshot slot
- `recover_i`  in  1  branch mispredict recovery
- `recover_tag_i`  in  ROB_W  slot to restore
- `flush_i`  in  1  discard all speculative allocations
- `free_count_o`  out  PREG_W+1  number of free pregs

## Operation
- Storage: circular buffer `buf[N_PHYS_REGS]` of PREG_W entries; pointers `head`, `tail`, `commit_head`, each PREG_W+1 bits (MSB is the wrap bit). Index is the low PREG_W bits. `free_count_o = tail - head` (modulo 2^(PREG_W+1)).
- Reset: `buf[k] = N_ARCH_REGS + k` for k < N_PHYS_REGS-N_ARCH_REGS; `head = commit_head = 0`; `tail = N_PHYS_REGS-N_ARCH_REGS`; all checkpoint slots = 0.
- Offer: `alloc_valid_o = (free_count_o != 0) & !recover_i & !flush_i`; `alloc_preg_o = buf[head[PREG_W-1:0]]`, which is combinational from the registered state.
- Pop: `alloc_inval_o = alloc_req_i & alloc_valid_o`; on pop, `head` increments by 1.
- Commit: `commit_i & commit_rd_used_i` writes `buf[tail] <= commit_old_preg_i`, increments `tail`, and increments `commit_head`. The push is processed every non-reset cycle, including during recover or flush.
- Checkpoint: `ckpt[checkpoint_tag_i] <= head_next`, where head_next is the value after this cycle's pop. It is ignored when recover_i or flush_i is asserted.
- Recover: `head <= ckpt[recover_tag_i]`.
- Flush: `head <= commit_head_next`, which includes this cycle's commit.
- Priority for `head`: rst > recover > flush > pop. If recover and flush are both asserted, flush's target wins only if recover is deasserted; recover has priority.
- No overflow is possible: total pregs are conserved, so `free_count_o <= N_PHYS_REGS - N_ARCH_REGS` always holds. The bench asserts this invariant.

## Timing
- Reset values: `alloc_valid_o = 1`, `alloc_preg_o = N_ARCH_REGS` (32), `alloc_inval_o = alloc_req_i` (combinational), `free_count_o = N_PHYS_REGS - N_ARCH_REGS` (96).
- Allocation is zero-latency: the preg is valid in the request cycle, and head advances at the next edge.
- There is no commit-to-alloc bypass. A preg freed in cycle t is first offered at t+1 at the earliest, and only when it reaches head.
- When empty (`free_count_o == 0`), `alloc_valid_o = 0` even if a commit pushes in the same cycle.
- Recover or flush in cycle t: no grant in cycle t. The restored head is visible at t+1.
- Wrap-around: pointers wrap at N_PHYS_REGS, with the MSB toggling. free_count stays correct across the wrap.
- Reset mid-operation returns every pointer and the buffer to their reset contents at the next edge.

## Test plan
- Reset, then 96 back-to-back requests -> pregs 32..127 are granted in order. On cycle 97, `alloc_valid_o = 0` and `free_count_o = 0`.
- Empty list; commit of old_preg 5 while alloc_req_i=1 -> no grant that cycle. Next cycle `alloc_preg_o = 5` and `free_count_o = 1`.
- Allocate 3 (32, 33, 34), checkpoint tag 2 in the same cycle as the 34 pop, allocate 35 and 36, then recover tag 2 -> next `alloc_preg_o = 35` and `free_count_o = 96 - 3 = 93`.
- Allocate 10, commit 4 (old pregs 1..4), then flush -> `head = commit_head = 4`, next `alloc_preg_o = 36`, `free_count_o = 96`.
- Recover and commit (old_preg 7) in the same cycle -> the push of 7 lands at tail, the head is restored, and free_count reflects both.
- 300 cycles of random alloc/commit/checkpoint/recover/flush -> conservation invariant holds, there are no duplicate pregs across list plus in-flight, and `alloc_preg_o` is never 0.

Source files
------------

// File: rtl/free_list_if.sv
// Rename-side port bundle of the physical-register free list.
// alloc_valid_o offers buf[head]; a grant (alloc_inval_o) occurs in any cycle
// where alloc_req_i and alloc_valid_o are both high. Commit pushes are always accepted.
interface free_list_if #(
   parameter int N_PHYS_REGS = 128,
   parameter int ROB_DEPTH   = 16,
   parameter int PREG_W      = $clog2(N_PHYS_REGS),
   parameter int ROB_W       = $clog2(ROB_DEPTH)
);
   logic              alloc_req_i;
   logic              alloc_valid_o;
   logic [PREG_W-1:0] alloc_preg_o;
   logic              alloc_inval_o;
   logic              commit_i;
   logic              commit_rd_used_i;
   logic [PREG_W-1:0] commit_old_preg_i;
   logic              checkpoint_take_i;
   logic [ROB_W-1:0]  checkpoint_tag_i;
   logic              recover_i;
   logic [ROB_W-1:0]  recover_tag_i;
   logic              flush_i;
   logic [PREG_W:0]   free_count_o;

   modport master (
      output alloc_req_i, commit_i, commit_rd_used_i, commit_old_preg_i,
             checkpoint_take_i, checkpoint_tag_i, recover_i, recover_tag_i, flush_i,
      input  alloc_valid_o, alloc_preg_o, alloc_inval_o, free_count_o
   );

   modport slave (
      input  alloc_req_i, commit_i, commit_rd_used_i, commit_old_preg_i,
             checkpoint_take_i, checkpoint_tag_i, recover_i, recover_tag_i, flush_i,
      output alloc_valid_o, alloc_preg_o, alloc_inval_o, free_count_o
   );
endinterface

// File: rtl/free_list.sv
// Circular-buffer physical-register free list with per-branch head checkpoints,
// branch recovery and full flush back to the committed head.
module free_list #(
   parameter int N_PHYS_REGS = 128,
   parameter int N_ARCH_REGS = 32,
   parameter int ROB_DEPTH   = 16,
   parameter int PREG_W      = $clog2(N_PHYS_REGS),
   parameter int ROB_W       = $clog2(ROB_DEPTH)
) (
   input  logic       clk,
   input  logic       rst,
   free_list_if.slave fl
);
   localparam int N_FREE = N_PHYS_REGS - N_ARCH_REGS;

   typedef logic [PREG_W:0] ptr_t;

   logic [PREG_W-1:0] fifo_mem [N_PHYS_REGS];
   ptr_t              ckpt [ROB_DEPTH];
   ptr_t              head;
   ptr_t              tail;
   ptr_t              commit_head;
   ptr_t              head_pop;
   ptr_t              head_next;
   ptr_t              commit_head_next;
   ptr_t              free_count;
   logic              offer;
   logic              pop;
   logic              push;
   logic              ckpt_write;

   always_comb begin
      free_count       = tail - head;
      offer            = (free_count != '0) && !fl.recover_i && !fl.flush_i;
      pop              = fl.alloc_req_i && offer;
      push             = fl.commit_i && fl.commit_rd_used_i;
      head_pop         = head + ptr_t'(pop);
      commit_head_next = commit_head + ptr_t'(push);
      ckpt_write       = fl.checkpoint_take_i && !fl.recover_i && !fl.flush_i;
      // Recover outranks flush, which outranks a plain pop.
      head_next = head_pop;
      if (fl.flush_i)   head_next = commit_head_next;
      if (fl.recover_i) head_next = ckpt[fl.recover_tag_i];
   end

   assign fl.alloc_valid_o = offer;
   assign fl.alloc_preg_o  = fifo_mem[head[PREG_W-1:0]];
   assign fl.alloc_inval_o = pop;
   assign fl.free_count_o  = free_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_PHYS_REGS; k++) begin
            fifo_mem[k] <= (k < N_FREE) ? PREG_W'(N_ARCH_REGS + k) : '0;
         end
         for (int t = 0; t < ROB_DEPTH; t++) begin
            ckpt[t] <= '0;
         end
         head        <= '0;
         tail        <= ptr_t'(N_FREE);
         commit_head <= '0;
      end else begin
         // The commit push proceeds even while recovering or flushing.
         if (push) begin
            fifo_mem[tail[PREG_W-1:0]] <= fl.commit_old_preg_i;
            tail                       <= tail + ptr_t'(1);
         end
         commit_head <= commit_head_next;
         head        <= head_next;
         if (ckpt_write) begin
            ckpt[fl.checkpoint_tag_i] <= head_pop;
         end
      end
   end
endmodule
